// File: rtl/var_comb_filter_if.sv
// Sample-path bus for var_comb_filter: input sample/control from the source,
// filtered sample and status back to downstream stages.
interface var_comb_filter_if #(
   parameter int BITWIDTH   = 32,
   parameter int TUNE_WIDTH = 16
) ();
   logic                  in_valid;
   logic [BITWIDTH-1:0]   sig_in;
   logic [TUNE_WIDTH-1:0] tuning_word;
   logic [1:0]            mode;
   logic                  sat_en;
   logic                  clear;
   logic                  out_valid;
   logic [BITWIDTH-1:0]   sig_out;
   logic                  trig_out;
   logic                  overflow;

   modport master (
      output in_valid, sig_in, tuning_word, mode, sat_en, clear,
      input  out_valid, sig_out, trig_out, overflow
   );

   modport slave (
      input  in_valid, sig_in, tuning_word, mode, sat_en, clear,
      output out_valid, sig_out, trig_out, overflow
   );
endinterface

// File: rtl/var_comb_filter.sv
// Multi-mode comb filter: y = x (+/-) h, where the hold register h is reloaded
// from the end of a DEPTH-sample delay line whenever the phase accumulator carries.
module var_comb_filter #(
   parameter int BITWIDTH   = 32,
   parameter int TUNE_WIDTH = 16,
   parameter int PA_WIDTH   = 23,
   parameter int DEPTH      = 4
) (
   input logic               clk,
   input logic               n_RST,
   var_comb_filter_if.slave  bus
);

   logic [PA_WIDTH-1:0]                pa_q, pa_d;
   logic [PA_WIDTH:0]                  pa_sum_s;
   logic                               trig_s;
   logic [BITWIDTH-1:0]                h_q, h_d;
   logic [DEPTH-1:0][BITWIDTH-1:0]     dly_q, dly_d;
   logic signed [BITWIDTH:0]           x_ext_s, h_ext_s, full_s;
   logic [BITWIDTH-1:0]                y_s;
   logic                               ovf_s;
   logic                               out_valid_q, out_valid_d;
   logic [BITWIDTH-1:0]                sig_out_q, sig_out_d;
   logic                               trig_q, trig_d;
   logic                               overflow_q, overflow_d;

   function automatic logic [BITWIDTH-1:0] clamp(input logic neg);
      return neg ? {1'b1, {(BITWIDTH-1){1'b0}}} : {1'b0, {(BITWIDTH-1){1'b1}}};
   endfunction

   // Datapath: accumulator carry, widened arithmetic and overflow handling.
   always_comb begin
      pa_sum_s = {1'b0, pa_q} + {{(PA_WIDTH-TUNE_WIDTH+1){1'b0}}, bus.tuning_word};
      trig_s   = pa_sum_s[PA_WIDTH];
      x_ext_s  = {bus.sig_in[BITWIDTH-1], bus.sig_in};
      h_ext_s  = {h_q[BITWIDTH-1], h_q};
      case (bus.mode)
         2'b00:   full_s = x_ext_s;
         2'b01:   full_s = x_ext_s - h_ext_s;
         2'b10:   full_s = x_ext_s + h_ext_s;
         default: full_s = h_ext_s;
      endcase
      // The sign bit and the extra top bit disagree exactly when the result is out of range.
      ovf_s = (full_s[BITWIDTH] != full_s[BITWIDTH-1]);
      if (ovf_s && bus.sat_en) begin
         y_s = clamp(full_s[BITWIDTH]);
      end else begin
         y_s = full_s[BITWIDTH-1:0];
      end
   end

   // Next-state selection: clear beats a valid sample; idle cycles hold state.
   always_comb begin
      pa_d        = pa_q;
      h_d         = h_q;
      dly_d       = dly_q;
      overflow_d  = overflow_q;
      sig_out_d   = sig_out_q;
      out_valid_d = 1'b0;
      trig_d      = 1'b0;
      if (bus.clear) begin
         pa_d       = '0;
         h_d        = '0;
         dly_d      = '0;
         overflow_d = 1'b0;
      end else if (bus.in_valid) begin
         pa_d        = pa_sum_s[PA_WIDTH-1:0];
         h_d         = trig_s ? dly_q[DEPTH-1] : h_q;
         for (int k = DEPTH - 1; k > 0; k--) begin
            dly_d[k] = dly_q[k-1];
         end
         dly_d[0]    = y_s;
         overflow_d  = overflow_q | ovf_s;
         sig_out_d   = y_s;
         out_valid_d = 1'b1;
         trig_d      = trig_s;
      end else begin
         out_valid_d = 1'b0;
      end
   end

   // State and output registers.
   always_ff @(posedge clk or negedge n_RST) begin
      if (!n_RST) begin
         pa_q        <= '0;
         h_q         <= '0;
         dly_q       <= '0;
         overflow_q  <= 1'b0;
         sig_out_q   <= '0;
         out_valid_q <= 1'b0;
         trig_q      <= 1'b0;
      end else begin
         pa_q        <= pa_d;
         h_q         <= h_d;
         dly_q       <= dly_d;
         overflow_q  <= overflow_d;
         sig_out_q   <= sig_out_d;
         out_valid_q <= out_valid_d;
         trig_q      <= trig_d;
      end
   end

   assign bus.out_valid = out_valid_q;
   assign bus.sig_out   = sig_out_q;
   assign bus.trig_out  = trig_q;
   assign bus.overflow  = overflow_q;

endmodule
